// File: rtl/maxpool_channel_sequencer_if.sv
// rtl/maxpool_channel_sequencer_if.sv - tensor, engine and result signals of the max-pool channel sequencer
//
// Purpose: bundles the producer handshake, the engine slice/result pair and the
// consumer handshake of maxpool_channel_sequencer into one parameterised interface.
// Ports (signals):
//   in_valid / in_ready   producer handshake, mp_input holds the H*W*D tensor (channel 0 at bit 0)
//   eng_in / eng_ch       current channel slice and its index, to the pooling engine
//   eng_out               pooled result of eng_in from the engine
//   out_valid / out_ready consumer handshake, mp_output holds the D-channel result (channel 0 at bit 0)
//   busy                  sequencer is running or holding a result
// Modports: slave = sequencer side, master = producer/engine/consumer side.
interface maxpool_channel_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 2,
    parameter int H          = 13,
    parameter int W          = 13,
    parameter int K          = 13
);
    localparam int OH   = H - K + 1;
    localparam int OW   = W - K + 1;
    localparam int CH_W = (D > 1) ? $clog2(D) : 1;

    logic                             in_valid;
    logic                             in_ready;
    logic [H*W*D*DATA_WIDTH-1:0]      mp_input;
    logic [H*W*DATA_WIDTH-1:0]        eng_in;
    logic [CH_W-1:0]                  eng_ch;
    logic [OH*OW*DATA_WIDTH-1:0]      eng_out;
    logic                             out_valid;
    logic                             out_ready;
    logic [OH*OW*D*DATA_WIDTH-1:0]    mp_output;
    logic                             busy;

    modport slave (
        input  in_valid, mp_input, eng_out, out_ready,
        output in_ready, eng_in, eng_ch, out_valid, mp_output, busy
    );

    modport master (
        output in_valid, mp_input, eng_out, out_ready,
        input  in_ready, eng_in, eng_ch, out_valid, mp_output, busy
    );
endinterface

// File: rtl/maxpool_channel_sequencer.sv
// rtl/maxpool_channel_sequencer.sv - time-multiplexes one single-channel max-pool engine over D channels
//
// Purpose: accepts a full H*W*D tensor, feeds one channel slice per pass to an
// external pooling engine, collects each pooled channel into mp_output and then
// offers the whole result to the consumer.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    maxpool_channel_sequencer_if.slave (producer, engine and consumer signals)
// Optional feature: define MPSEQ_REUSE_EN to skip the channel passes when an
// accepted tensor equals the previously completed one (result reused as is).
//
// Timing: the first RUN cycle loads channel 0 into the eng_in register, then
// each channel gets ENG_LAT+1 cycles with eng_in held constant, so a tensor
// accepted at edge T is offered from edge T+1+D*(ENG_LAT+1).
module maxpool_channel_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 2,
    parameter int H          = 13,
    parameter int W          = 13,
    parameter int K          = 13,
    parameter int ENG_LAT    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    maxpool_channel_sequencer_if.slave    bus
);
    localparam int OH        = H - K + 1;
    localparam int OW        = W - K + 1;
    localparam int SLICE_IN  = H * W * DATA_WIDTH;
    localparam int SLICE_OUT = OH * OW * DATA_WIDTH;
    localparam int CH_W      = (D > 1) ? $clog2(D) : 1;
    localparam int LAT_W     = (ENG_LAT > 0) ? $clog2(ENG_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [D*SLICE_IN-1:0]     buf_q;
    logic [D*SLICE_OUT-1:0]    mp_output_q;
    logic [SLICE_IN-1:0]       eng_in_q;
    logic [CH_W-1:0]           ch;
    logic [CH_W-1:0]           ch_inc;
    logic [LAT_W-1:0]          cnt;
    // Low during the first RUN cycle, while channel 0 is loaded into eng_in.
    logic                      primed;

    logic                      accept;
    logic                      last_ch;
    logic                      pass_end;
    logic                      reuse_skip;

    assign accept   = bus.in_valid && bus.in_ready;
    assign last_ch  = (ch == CH_W'(D - 1));
    assign ch_inc   = ch + CH_W'(1);
    assign pass_end = primed && (cnt == LAT_W'(ENG_LAT));

`ifdef MPSEQ_REUSE_EN
    // result_ok marks mp_output as the finished result of buf_q; skip_q
    // records at accept time whether the new tensor matched that buffer.
    logic result_ok;
    logic skip_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_ok <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            if (state == DONE && bus.out_ready) begin
                result_ok <= 1'b1;
            end
            if (accept) begin
                skip_q <= result_ok && (bus.mp_input == buf_q);
            end
        end
    end

    assign reuse_skip = !primed && skip_q;
`else
    assign reuse_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (reuse_skip || (pass_end && last_ch)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            mp_output_q <= '0;
            eng_in_q    <= '0;
            ch          <= '0;
            cnt         <= '0;
            primed      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        buf_q  <= bus.mp_input;
                        ch     <= '0;
                        cnt    <= '0;
                        primed <= 1'b0;
                    end
                end
                RUN: begin
                    if (!primed) begin
                        eng_in_q <= buf_q[ch*SLICE_IN +: SLICE_IN];
                        primed   <= 1'b1;
                    end else if (cnt == LAT_W'(ENG_LAT)) begin
                        mp_output_q[ch*SLICE_OUT +: SLICE_OUT] <= bus.eng_out;
                        if (!last_ch) begin
                            // Next slice goes out on the same edge so the
                            // following pass gets its full ENG_LAT+1 cycles.
                            ch       <= ch_inc;
                            cnt      <= '0;
                            eng_in_q <= buf_q[ch_inc*SLICE_IN +: SLICE_IN];
                        end
                    end else begin
                        cnt <= cnt + LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.eng_in    = eng_in_q;
    assign bus.eng_ch    = ch;
    assign bus.mp_output = mp_output_q;
endmodule

// File: tb/tb_maxpool_channel_sequencer.sv
// tb/tb_maxpool_channel_sequencer.sv - directed bench for maxpool_channel_sequencer
module tb_maxpool_channel_sequencer;
    localparam int DW      = 16;
    localparam int D       = 2;
    localparam int H       = 13;
    localparam int W       = 13;
    localparam int K       = 13;
    localparam int OH      = H - K + 1;
    localparam int OW      = W - K + 1;
    localparam int HW      = H * W;
    localparam int IN_SL   = HW * DW;
    localparam int OUT_SL  = OH * OW * DW;
    localparam int IN_BITS = IN_SL * D;

    localparam logic [31:0] EXP_A = 32'h0100_7FFF;
    localparam logic [31:0] EXP_B = 32'h1234_FFFF;
    localparam logic [31:0] EXP_C = 32'h0001_0010;

`ifdef MPSEQ_REUSE_EN
    localparam int REUSE_LAT = 1;
`else
    localparam int REUSE_LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    maxpool_channel_sequencer_if #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .K(K)) b0 ();
    maxpool_channel_sequencer_if #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .K(K)) b1 ();

    maxpool_channel_sequencer #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .K(K), .ENG_LAT(0)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    maxpool_channel_sequencer #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .K(K), .ENG_LAT(2)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    function automatic logic [OUT_SL-1:0] pool(input logic [IN_SL-1:0] x);
        logic [OUT_SL-1:0] r;
        logic [DW-1:0]     m;
        logic [DW-1:0]     v;
        r = '0;
        for (int oy = 0; oy < OH; oy++) begin
            for (int ox = 0; ox < OW; ox++) begin
                m = '0;
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        v = x[((oy + ky) * W + ox + kx) * DW +: DW];
                        if (v > m) m = v;
                    end
                end
                r[(oy * OW + ox) * DW +: DW] = m;
            end
        end
        return r;
    endfunction

    // Zero-latency engine for u0, two-register delayed engine for u1.
    logic [IN_SL-1:0] d1 = '0;
    logic [IN_SL-1:0] d2 = '0;
    always @(posedge clk) begin
        d1 <= b1.eng_in;
        d2 <= d1;
    end
    assign b0.eng_out = pool(b0.eng_in);
    assign b1.eng_out = pool(d2);

    function automatic logic [IN_BITS-1:0] make_tensor(
        input logic [DW-1:0] base0, input int i0, input logic [DW-1:0] hot0,
        input logic [DW-1:0] base1, input int i1, input logic [DW-1:0] hot1);
        logic [IN_BITS-1:0] t;
        t = '0;
        for (int e = 0; e < HW; e++) begin
            t[e * DW +: DW]        = (e == i0) ? hot0 : base0;
            t[(HW + e) * DW +: DW] = (e == i1) ? hot1 : base1;
        end
        return t;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [IN_BITS-1:0] ta;
    logic [IN_BITS-1:0] tb_t;
    logic [IN_BITS-1:0] tc;
    logic [IN_BITS-1:0] garbage;
    int lat;

    // Starts at #1 after an edge with u0 idle; returns edges from accept to out_valid.
    task automatic send0(input logic [IN_BITS-1:0] t, output int n);
        b0.mp_input = t;
        b0.in_valid = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        b0.mp_input = garbage;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!b0.out_valid && n < 50);
    endtask

    task automatic release0();
        b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.out_ready = 1'b0;
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.out_ready = 1'b0; b0.mp_input = '0;
        b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.mp_input = '0;
        ta      = make_tensor(16'h0001, 84, 16'h7FFF, 16'h0100, 0, 16'h0100);
        tb_t    = make_tensor(16'h0003, 0, 16'hFFFF, 16'h0200, 168, 16'h1234);
        tc      = make_tensor(16'h0010, 0, 16'h0010, 16'h0000, 168, 16'h0001);
        garbage = {(H * W * D){16'hDEAD}};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", b0.in_ready, 0);
        check_eq("rst_out_valid", b0.out_valid, 0);
        check_eq("rst_busy", b0.busy, 0);
        check_eq("rst_mp_output", b0.mp_output, 0);
        check_eq("rst_eng_ch", b0.eng_ch, 0);
        check_eq("rst_eng_in_zero", (b0.eng_in == '0), 1);
        reset = 1'b0;
        #1;
        check_eq("rel_in_ready", b0.in_ready, 1);

        // Tensor A, ENG_LAT=0, input changed right after accept
        b0.mp_input = ta;
        b0.in_valid = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        b0.mp_input = garbage;
        check_eq("a_busy_t0", b0.busy, 1);
        check_eq("a_in_ready_t0", b0.in_ready, 0);
        @(posedge clk); #1;
        check_eq("a_eng_ch_t1", b0.eng_ch, 0);
        check_eq("a_eng_in_t1", (b0.eng_in == ta[0 +: IN_SL]), 1);
        check_eq("a_out_valid_t1", b0.out_valid, 0);
        @(posedge clk); #1;
        check_eq("a_eng_ch_t2", b0.eng_ch, 1);
        check_eq("a_eng_in_t2", (b0.eng_in == ta[IN_SL +: IN_SL]), 1);
        check_eq("a_out_valid_t2", b0.out_valid, 0);
        @(posedge clk); #1;
        check_eq("a_out_valid_t3", b0.out_valid, 1);
        check_eq("a_mp_output", b0.mp_output, EXP_A);

        // Back-pressure in DONE with a new tensor waiting
        b0.mp_input = tb_t;
        b0.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", b0.out_valid, 1);
            check_eq("hold_in_ready", b0.in_ready, 0);
            check_eq("hold_mp_output", b0.mp_output, EXP_A);
        end
        b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.out_ready = 1'b0;
        check_eq("exit_out_valid", b0.out_valid, 0);
        check_eq("exit_in_ready", b0.in_ready, 1);
        check_eq("exit_busy", b0.busy, 0);
        check_eq("exit_mp_output_kept", b0.mp_output, EXP_A);
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        b0.mp_input = garbage;
        check_eq("b_busy", b0.busy, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!b0.out_valid && lat < 50);
        check_eq("b_latency", lat, 3);
        check_eq("b_mp_output", b0.mp_output, EXP_B);
        release0();

        // Reset in the second RUN cycle
        b0.mp_input = tc;
        b0.in_valid = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_out_valid", b0.out_valid, 0);
        check_eq("abort_busy", b0.busy, 0);
        check_eq("abort_mp_output", b0.mp_output, 0);
        check_eq("abort_eng_ch", b0.eng_ch, 0);
        check_eq("abort_eng_in_zero", (b0.eng_in == '0), 1);
        check_eq("abort_in_ready", b0.in_ready, 0);
        reset = 1'b0;
        #1;
        check_eq("abort_rel_in_ready", b0.in_ready, 1);
        send0(tc, lat);
        check_eq("c_latency", lat, 3);
        check_eq("c_mp_output", b0.mp_output, EXP_C);
        release0();

        // Same tensor again, then a different one
        send0(tc, lat);
        check_eq("repeat_latency", lat, REUSE_LAT);
        check_eq("repeat_mp_output", b0.mp_output, EXP_C);
        release0();
        send0(ta, lat);
        check_eq("new_latency", lat, 3);
        check_eq("new_mp_output", b0.mp_output, EXP_A);
        release0();

        // ENG_LAT=2 instance
        b1.mp_input = ta;
        b1.in_valid = 1'b1;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        b1.mp_input = garbage;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check_eq("l2_eng_ch", b1.eng_ch, (k <= 3) ? 0 : 1);
            check_eq("l2_eng_in", (b1.eng_in == ((k <= 3) ? ta[0 +: IN_SL] : ta[IN_SL +: IN_SL])), 1);
            check_eq("l2_out_valid", b1.out_valid, (k == 7) ? 1 : 0);
        end
        check_eq("l2_mp_output", b1.mp_output, EXP_A);
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b1.out_ready = 1'b0;
        check_eq("l2_exit_out_valid", b1.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
